// File: rtl/i2s_tx_stereo_param_pkg.sv
// Shared types and constants for the stereo I2S / left-justified transmitter.
// The size decode maps the 3-bit sample_size code to a bit count.
package i2s_tx_stereo_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam logic [2:0] SIZE_8  = 3'd0;
  localparam logic [2:0] SIZE_12 = 3'd1;
  localparam logic [2:0] SIZE_16 = 3'd2;
  localparam logic [2:0] SIZE_24 = 3'd3;
  localparam logic [2:0] SIZE_32 = 3'd4;

  // Codes 5..7 are reserved and fall back to 16 bits.
  function automatic logic [5:0] size_bits(input logic [2:0] code);
    case (code)
      SIZE_8:  return 6'd8;
      SIZE_12: return 6'd12;
      SIZE_16: return 6'd16;
      SIZE_24: return 6'd24;
      SIZE_32: return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tx_stereo_param_bclk_gen.sv
// Bit clock generator: divides clk by 2*CLK_DIV while run is high and flags
// the cycle in which bclk goes from 1 to 0.
module i2s_tx_stereo_param_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic fall_event
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt_reg;
  logic          bclk_reg;
  logic          wrap;

  assign wrap       = run && (div_cnt_reg == CW'(CLK_DIV - 1));
  assign fall_event = wrap && bclk_reg;
  assign bclk       = bclk_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      bclk_reg    <= ~bclk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_stereo_param.sv
// Stereo I2S / left-justified serial transmitter with runtime sample size.
// Holding register + handshake, frame FSM, bit index and the two slot shift registers.
module i2s_tx_stereo_param
  import i2s_tx_stereo_param_pkg::*;
#(
  parameter int MAX_WIDTH = 32,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [2:0]           sample_size,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [MAX_WIDTH-1:0] s_left,
  input  logic [MAX_WIDTH-1:0] s_right,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 underrun,
  output logic                 busy
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_FIRST = BW'(SLOT_BITS);
  localparam logic [BW-1:0] SLOT_PRE   = BW'(SLOT_BITS - 1);

  state_t                state_reg;
  logic [BW-1:0]         bit_idx_reg;
  logic                  hold_full_reg;
  logic [MAX_WIDTH-1:0]  hold_left_reg;
  logic [MAX_WIDTH-1:0]  hold_right_reg;
  logic [MAX_WIDTH-1:0]  left_sr_reg;
  logic [MAX_WIDTH-1:0]  right_sr_reg;
  logic                  mode_reg;
  logic                  lrclk_reg;
  logic                  sdata_reg;
  logic                  underrun_reg;
  logic                  busy_reg;

  logic                  run;
  logic                  fall_event;
  logic                  stop;
  logic                  frame_step;
  logic                  load;
  logic                  accept;
  logic [5:0]            size_dec;
  logic [5:0]            size_n;
  logic [5:0]            shamt;
  logic [MAX_WIDTH-1:0]  src_left;
  logic [MAX_WIDTH-1:0]  src_right;
  logic [MAX_WIDTH-1:0]  cur_left;
  logic [MAX_WIDTH-1:0]  cur_right;
  logic                  in_right;
  logic                  eff_mode;
  logic                  lrclk_next;
  logic [BW-1:0]         bit_idx_next;

  i2s_tx_stereo_param_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bclk      (bclk),
    .fall_event(fall_event)
  );

  assign run = (state_reg != ST_IDLE);

  // Draining ends on the fall event that would have started a new frame, so the
  // last bit of the frame keeps its full BCLK period.
  assign stop       = fall_event && (state_reg == ST_DRAIN) && !enable && (bit_idx_reg == '0);
  assign frame_step = fall_event && run && !stop;
  assign load       = frame_step && (bit_idx_reg == '0);
  assign accept     = s_valid && !hold_full_reg;

  // Samples are left-aligned at load; bits above the size fall off the top.
  assign size_dec  = size_bits(sample_size);
  assign size_n    = (size_dec > 6'(MAX_WIDTH)) ? 6'(MAX_WIDTH) : size_dec;
  assign shamt     = 6'(MAX_WIDTH) - size_n;
  assign src_left  = hold_full_reg ? hold_left_reg  : '0;
  assign src_right = hold_full_reg ? hold_right_reg : '0;
  assign cur_left  = load ? (src_left  << shamt) : left_sr_reg;
  assign cur_right = load ? (src_right << shamt) : right_sr_reg;

  assign in_right     = (bit_idx_reg >= SLOT_FIRST);
  assign eff_mode     = load ? mode : mode_reg;
  assign lrclk_next   = (eff_mode == MODE_LJ) ? in_right
                      : ((bit_idx_reg >= SLOT_PRE) && (bit_idx_reg != LAST_BIT));
  assign bit_idx_next = (bit_idx_reg == LAST_BIT) ? '0 : bit_idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      bit_idx_reg    <= '0;
      hold_full_reg  <= 1'b0;
      hold_left_reg  <= '0;
      hold_right_reg <= '0;
      left_sr_reg    <= '0;
      right_sr_reg   <= '0;
      mode_reg       <= MODE_I2S;
      lrclk_reg      <= 1'b0;
      sdata_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      // A same-cycle accept refills the register the loader is emptying.
      if (accept) begin
        hold_full_reg  <= 1'b1;
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
      end else if (load) begin
        hold_full_reg  <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!enable) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (enable) begin
            state_reg <= ST_RUN;
          end else if (stop) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      underrun_reg <= load && !hold_full_reg;

      if (stop) begin
        sdata_reg <= 1'b0;
        lrclk_reg <= 1'b0;
      end else if (frame_step) begin
        bit_idx_reg <= bit_idx_next;
        lrclk_reg   <= lrclk_next;
        if (load) mode_reg <= mode;
        if (in_right) begin
          sdata_reg    <= cur_right[MAX_WIDTH-1];
          right_sr_reg <= cur_right << 1;
          left_sr_reg  <= cur_left;
        end else begin
          sdata_reg    <= cur_left[MAX_WIDTH-1];
          left_sr_reg  <= cur_left << 1;
          right_sr_reg <= cur_right;
        end
      end
    end
  end

  assign s_ready  = !hold_full_reg;
  assign lrclk    = lrclk_reg;
  assign sdata    = sdata_reg;
  assign underrun = underrun_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_i2s_tx_stereo_param.sv
// Directed bench: captures sdata/lrclk on every bclk rise and checks whole frames
// against hand-computed words (MAX_WIDTH=32, SLOT_BITS=32, CLK_DIV=2).
module tb_i2s_tx_stereo_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mode;
  logic [2:0]  sample_size;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_left;
  logic [31:0] s_right;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx_stereo_param #(
    .MAX_WIDTH(32),
    .SLOT_BITS(32),
    .CLK_DIV  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .sample_size(sample_size),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .underrun   (underrun),
    .busy       (busy)
  );

  // Capture: one entry per bclk rise, plus underrun pulse bookkeeping.
  logic cap_sd [0:4095];
  logic cap_lr [0:4095];
  int   rise_cnt    = 0;
  int   cyc         = 0;
  int   last_rise   = 0;
  int   rise_period = 0;
  int   ur_cnt      = 0;
  int   last_ur     = 0;
  int   ur_period   = 0;
  logic bclk_q      = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    bclk_q <= bclk;
    if (bclk === 1'b1 && bclk_q === 1'b0 && rise_cnt < 4096) begin
      cap_sd[rise_cnt] <= sdata;
      cap_lr[rise_cnt] <= lrclk;
      rise_cnt         <= rise_cnt + 1;
      rise_period      <= cyc - last_rise;
      last_rise        <= cyc;
    end
    if (underrun === 1'b1) begin
      ur_cnt    <= ur_cnt + 1;
      ur_period <= cyc - last_ur;
      last_ur   <= cyc;
    end
  end

  localparam logic [31:0] STIM_L [9] = '{32'h11223344, 32'h80000000, 32'h7FFFFFFF,
                                         32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF,
                                         32'h5A5A5A5A, 32'h01234567, 32'hCAFEBABE};
  localparam logic [31:0] STIM_R [9] = '{32'h55667788, 32'h00000001, 32'h80000001,
                                         32'hFEEDF00D, 32'hA5A5A5A5, 32'h00000000,
                                         32'h3C3C3C3C, 32'h89ABCDEF, 32'h13572468};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rises(input int target, input string tag);
    int n = 0;
    while (rise_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, 32'(rise_cnt >= target), 32'd1);
  endtask

  function automatic logic [31:0] sd_word(input int start);
    logic [31:0] w = '0;
    for (int k = 0; k < 32; k++) w = {w[30:0], cap_sd[start + k]};
    return w;
  endfunction

  function automatic logic [31:0] lr_word(input int start);
    logic [31:0] w = '0;
    for (int k = 0; k < 32; k++) w = {w[30:0], cap_lr[start + k]};
    return w;
  endfunction

  // Bit 0 of frame f starts at index base+1+64*f (the first rise precedes bit 0).
  function automatic int fpos(input int base, input int f, input int slot);
    return base + 1 + 64 * f + 32 * slot;
  endfunction

  initial begin
    int base;
    int base2;
    int base3;
    int ur_b;
    int n;
    logic rdy;
    int acc_cyc [9];

    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; sample_size = 3'd2;
    s_valid = 1'b0; s_left = '0; s_right = '0;
    repeat (3) tick();
    check("rst_bclk",     32'(bclk),     32'd0);
    check("rst_lrclk",    32'(lrclk),    32'd0);
    check("rst_sdata",    32'(sdata),    32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_s_ready",  32'(s_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // I2S, 16-bit samples
    s_left = 32'h0000A5A5; s_right = 32'h00000F0F; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("t1_s_ready_low", 32'(s_ready), 32'd0);
    enable = 1'b1;
    base = rise_cnt;
    wait_rises(fpos(base, 1, 0), "t1_frame0");
    check("t1_left",     sd_word(fpos(base, 0, 0)), 32'hA5A50000);
    check("t1_right",    sd_word(fpos(base, 0, 1)), 32'h0F0F0000);
    check("t1_lr_left",  lr_word(fpos(base, 0, 0)), 32'h00000001);
    check("t1_lr_right", lr_word(fpos(base, 0, 1)), 32'hFFFFFFFE);
    check("t1_busy",     32'(busy),        32'd1);
    check("t1_bclk_per", 32'(rise_period), 32'd4);
    check("t1_no_ur",    32'(ur_cnt),      32'd0);
    $display("frame0 L=%08h R=%08h", sd_word(fpos(base, 0, 0)), sd_word(fpos(base, 0, 1)));

    // No data: underrun once per frame, zeros on the line
    wait_rises(fpos(base, 3, 0), "t3_frames12");
    check("t3_f1_left",  sd_word(fpos(base, 1, 0)), 32'h0);
    check("t3_f1_right", sd_word(fpos(base, 1, 1)), 32'h0);
    check("t3_f2_left",  sd_word(fpos(base, 2, 0)), 32'h0);
    check("t3_f2_right", sd_word(fpos(base, 2, 1)), 32'h0);
    check("t3_ur_cnt",   32'(ur_cnt),    32'd2);
    check("t3_ur_per",   32'(ur_period), 32'd256);

    // Mid-frame switch to left-justified 24-bit; takes effect at frame 4
    wait_rises(fpos(base, 3, 0) + 11, "t2_midframe");
    mode = 1'b1; sample_size = 3'd3;
    s_left = 32'hFF800001; s_right = 32'h00123456; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    wait_rises(fpos(base, 4, 0) + 6, "t2_frame4_start");
    check("t2_f3_lr_right", lr_word(fpos(base, 3, 1)), 32'hFFFFFFFE);

    // Stream 9 pairs back-to-back at 32 bits; the last one is used by the drain test
    sample_size = 3'd4;
    ur_b = ur_cnt;
    for (int i = 0; i < 9; i++) begin
      s_left = STIM_L[i]; s_right = STIM_R[i]; s_valid = 1'b1;
      n = 0;
      do begin
        rdy = s_ready;
        tick();
        n++;
      end while (!rdy && n < 400);
      acc_cyc[i] = cyc;
      check($sformatf("t4_accept%0d", i), 32'(rdy), 32'd1);
      $display("pair %0d accepted L=%08h R=%08h", i, STIM_L[i], STIM_R[i]);
    end
    s_valid = 1'b0;
    check("t4_accept_spacing", 32'(acc_cyc[8] - acc_cyc[1]), 32'd1792);
    check("t2_f4_left",     sd_word(fpos(base, 4, 0)), 32'h80000100);
    check("t2_f4_right",    sd_word(fpos(base, 4, 1)), 32'h12345600);
    check("t2_f4_lr_left",  lr_word(fpos(base, 4, 0)), 32'h00000000);
    check("t2_f4_lr_right", lr_word(fpos(base, 4, 1)), 32'hFFFFFFFF);

    // Drop enable at b=10 of frame 13
    wait_rises(fpos(base, 13, 0) + 11, "t5_b10");
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 600) begin
      tick();
      n++;
    end
    check("t5_busy",     32'(busy),  32'd0);
    check("t5_bclk",     32'(bclk),  32'd0);
    check("t5_lrclk",    32'(lrclk), 32'd0);
    check("t5_sdata",    32'(sdata), 32'd0);
    check("t5_rise_cnt", 32'(rise_cnt), 32'(fpos(base, 14, 0)));
    check("t4_no_ur",    32'(ur_cnt),   32'(ur_b));
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t4_f%0d_left", 5 + i),  sd_word(fpos(base, 5 + i, 0)), STIM_L[i]);
      check($sformatf("t4_f%0d_right", 5 + i), sd_word(fpos(base, 5 + i, 1)), STIM_R[i]);
      check($sformatf("t4_f%0d_lr", 5 + i),    lr_word(fpos(base, 5 + i, 1)), 32'hFFFFFFFF);
    end

    // Reset mid-frame with a pair pending
    enable = 1'b1;
    base2 = rise_cnt;
    wait_rises(fpos(base2, 0, 0) + 16, "t6_b15");
    s_left = 32'h12345678; s_right = 32'h9ABCDEF0; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("t6_pending", 32'(s_ready), 32'd0);
    wait_rises(fpos(base2, 0, 0) + 21, "t6_b20");
    rst_n = 1'b0;
    tick();
    check("t6_rst_bclk",     32'(bclk),     32'd0);
    check("t6_rst_lrclk",    32'(lrclk),    32'd0);
    check("t6_rst_sdata",    32'(sdata),    32'd0);
    check("t6_rst_underrun", 32'(underrun), 32'd0);
    check("t6_rst_busy",     32'(busy),     32'd0);
    check("t6_rst_s_ready",  32'(s_ready),  32'd1);
    rst_n = 1'b1;
    base3 = rise_cnt;
    ur_b  = ur_cnt;
    wait_rises(fpos(base3, 1, 0), "t6_restart");
    check("t6_left",  sd_word(fpos(base3, 0, 0)), 32'h0);
    check("t6_right", sd_word(fpos(base3, 0, 1)), 32'h0);
    check("t6_ur",    32'(ur_cnt), 32'(ur_b + 1));

    enable = 1'b0;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
